leg_angle_scheduler: RTL and testbench

- Time-multiplexes one shared servo-angle datapath across all platform legs.
- On each frame request it snapshots every leg vector and issues one vector per cycle into the datapath, tagged with its leg index.
- Matches returning results to legs through an in-order tag FIFO and publishes a coherent per-leg bank of LUTin/atan values with a frame_done pulse.
- Sits between the inverse-kinematics block (leg vectors) and the arcsin LUT / servo PWM stage.

---
 rtl/leg_angle_scheduler_pkg.sv | 15 +
 rtl/leg_angle_scheduler_if.sv | 29 ++
 rtl/leg_angle_scheduler_leg_tag_fifo.sv | 54 +++++
 rtl/leg_angle_scheduler.sv | 166 ++++++++++++++++
 tb/tb_leg_angle_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/leg_angle_scheduler_pkg.sv
// rtl/leg_angle_scheduler_pkg.sv - shared field widths, default leg count and FSM encoding
package leg_angle_scheduler_pkg;

  localparam int VEC_W        = 9;
  localparam int LUTIN_W      = 17;
  localparam int ATAN_W       = 13;
  localparam int DEF_NUM_LEGS = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/leg_angle_scheduler_if.sv
// rtl/leg_angle_scheduler_if.sv - issue/result bundle between scheduler and shared angle datapath
interface leg_angle_scheduler_if
  import leg_angle_scheduler_pkg::*;
#(
  parameter int LEG_W = 3
) ();

  logic                      dp_validIn;
  logic signed [VEC_W-1:0]   dp_lx;
  logic signed [VEC_W-1:0]   dp_ly;
  logic signed [VEC_W-1:0]   dp_lz;
  logic [LEG_W-1:0]          dp_leg;
  logic                      dp_validOut;
  logic signed [LUTIN_W-1:0] dp_LUTin;
  logic signed [ATAN_W-1:0]  dp_atan;

  // Scheduler side: issues vectors, receives results.
  modport master (
    output dp_validIn, dp_lx, dp_ly, dp_lz, dp_leg,
    input  dp_validOut, dp_LUTin, dp_atan
  );

  // Datapath side: consumes vectors, returns results.
  modport slave (
    input  dp_validIn, dp_lx, dp_ly, dp_lz, dp_leg,
    output dp_validOut, dp_LUTin, dp_atan
  );

endinterface

// File: rtl/leg_angle_scheduler_leg_tag_fifo.sv
// rtl/leg_angle_scheduler_leg_tag_fifo.sv - in-order leg tag FIFO with simultaneous push/pop
module leg_tag_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/leg_angle_scheduler.sv
// rtl/leg_angle_scheduler.sv - time-multiplexes one servo-angle datapath across all legs per frame
module leg_angle_scheduler
  import leg_angle_scheduler_pkg::*;
#(
  parameter int NUM_LEGS  = DEF_NUM_LEGS,
  parameter int TAG_DEPTH = 8,
  parameter int LEG_W     = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [VEC_W*NUM_LEGS-1:0]     lx_all,
  input  logic [VEC_W*NUM_LEGS-1:0]     ly_all,
  input  logic [VEC_W*NUM_LEGS-1:0]     lz_all,
  output logic                          busy,
  leg_angle_scheduler_if.master         dpif,
  output logic [LUTIN_W*NUM_LEGS-1:0]   lutin_all,
  output logic [ATAN_W*NUM_LEGS-1:0]    atan_all,
  output logic                          frame_done,
  output logic                          err_orphan
);

  localparam int CNT_W = LEG_W + 1;

  state_t                        state;
  state_t                        state_nxt;
  logic [VEC_W*NUM_LEGS-1:0]     snap_lx;
  logic [VEC_W*NUM_LEGS-1:0]     snap_ly;
  logic [VEC_W*NUM_LEGS-1:0]     snap_lz;
  logic [LUTIN_W*NUM_LEGS-1:0]   shadow_lutin;
  logic [ATAN_W*NUM_LEGS-1:0]    shadow_atan;
  logic [LEG_W-1:0]              issue_idx;
  logic [CNT_W-1:0]              rx_cnt;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [LEG_W-1:0]              fifo_head;
  logic                          pop;
  logic                          accept;
  logic                          issue;
  logic                          done;

  // A result only retires a tag when one is outstanding; otherwise it is an orphan.
  assign pop  = dpif.dp_validOut && !fifo_empty;
  assign busy = (state != ST_IDLE);

  leg_tag_fifo #(
    .W     (LEG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (issue),
    .push_data (issue_idx),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Frame state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus the accept/issue/complete strobes that steer the datapath registers.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!fifo_full || pop) begin
          issue = 1'b1;
          if (issue_idx == LEG_W'(NUM_LEGS - 1)) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && (rx_cnt == CNT_W'(NUM_LEGS - 1))) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Snapshot capture and issue sequencing; registered dp_* outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_lx         <= '0;
      snap_ly         <= '0;
      snap_lz         <= '0;
      issue_idx       <= '0;
      dpif.dp_validIn <= 1'b0;
      dpif.dp_lx      <= '0;
      dpif.dp_ly      <= '0;
      dpif.dp_lz      <= '0;
      dpif.dp_leg     <= '0;
    end else begin
      if (accept) begin
        snap_lx   <= lx_all;
        snap_ly   <= ly_all;
        snap_lz   <= lz_all;
        issue_idx <= '0;
      end else if (issue) begin
        issue_idx <= issue_idx + 1'b1;
      end
      dpif.dp_validIn <= issue;
      if (issue) begin
        dpif.dp_lx  <= snap_lx[issue_idx*VEC_W +: VEC_W];
        dpif.dp_ly  <= snap_ly[issue_idx*VEC_W +: VEC_W];
        dpif.dp_lz  <= snap_lz[issue_idx*VEC_W +: VEC_W];
        dpif.dp_leg <= issue_idx;
      end
    end
  end

  // Result capture into the shadow bank, indexed by the tag that left the FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_cnt       <= '0;
      shadow_lutin <= '0;
      shadow_atan  <= '0;
      err_orphan   <= 1'b0;
    end else begin
      if (accept)   rx_cnt <= '0;
      else if (pop) rx_cnt <= rx_cnt + 1'b1;
      if (pop) begin
        shadow_lutin[fifo_head*LUTIN_W +: LUTIN_W] <= dpif.dp_LUTin;
        shadow_atan[fifo_head*ATAN_W +: ATAN_W]    <= dpif.dp_atan;
      end
      if (dpif.dp_validOut && fifo_empty) err_orphan <= 1'b1;
    end
  end

  // Publish the whole bank at once; the final result bypasses the shadow so it lands this edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lutin_all  <= '0;
      atan_all   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done;
      if (done) begin
        for (int k = 0; k < NUM_LEGS; k++) begin
          if (fifo_head == LEG_W'(k)) begin
            lutin_all[k*LUTIN_W +: LUTIN_W] <= dpif.dp_LUTin;
            atan_all[k*ATAN_W +: ATAN_W]    <= dpif.dp_atan;
          end else begin
            lutin_all[k*LUTIN_W +: LUTIN_W] <= shadow_lutin[k*LUTIN_W +: LUTIN_W];
            atan_all[k*ATAN_W +: ATAN_W]    <= shadow_atan[k*ATAN_W +: ATAN_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_leg_angle_scheduler.sv
// tb/tb_leg_angle_scheduler.sv - scoreboard bench with D=5 stub datapaths for depth-8 and depth-2 tag FIFOs
module tb_leg_angle_scheduler;
  import leg_angle_scheduler_pkg::*;

  localparam int NL = 6;
  localparam int D  = 5;

  typedef struct {
    logic [2:0] leg;
    logic [8:0] lx;
    logic [8:0] ly;
    logic [8:0] lz;
    int         cyc;
  } iss_t;

  typedef struct {
    logic [17*NL-1:0] lut;
    logic [13*NL-1:0] atan;
    int               cyc;
  } bank_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic inj_a = 1'b0;
  logic [9*NL-1:0]  lx_all, ly_all, lz_all;
  logic             busy_a, busy_b, fd_a, fd_b, orph_a, orph_b;
  logic [17*NL-1:0] lut_a, lut_b;
  logic [13*NL-1:0] atan_a, atan_b;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int ta0 = 0;
  int n_iss_a = 0;
  int n_fd_b = 0;
  int b_issued = 0;
  int b_results = 0;
  int b_max_out = 0;

  iss_t  qa_iss[$];
  iss_t  qb_iss[$];
  bank_t qa_bank[$];
  bank_t qb_bank[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  leg_angle_scheduler_if #(.LEG_W(3)) ifa ();
  leg_angle_scheduler_if #(.LEG_W(3)) ifb ();

  leg_angle_scheduler #(.NUM_LEGS(NL), .TAG_DEPTH(8), .LEG_W(3)) u_dut_a (
    .clock(clock), .reset(reset), .start(start_a),
    .lx_all(lx_all), .ly_all(ly_all), .lz_all(lz_all),
    .busy(busy_a), .dpif(ifa), .lutin_all(lut_a), .atan_all(atan_a),
    .frame_done(fd_a), .err_orphan(orph_a)
  );

  leg_angle_scheduler #(.NUM_LEGS(NL), .TAG_DEPTH(2), .LEG_W(3)) u_dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .lx_all(lx_all), .ly_all(ly_all), .lz_all(lz_all),
    .busy(busy_b), .dpif(ifb), .lutin_all(lut_b), .atan_all(atan_b),
    .frame_done(fd_b), .err_orphan(orph_b)
  );

  // Stub datapaths: D-cycle pipelines returning LUTin=100*leg, atan=-leg.
  logic [D-1:0] av, bv;
  logic [2:0]   aleg [D];
  logic [2:0]   bleg [D];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      av <= '0;
      bv <= '0;
      for (int i = 0; i < D; i++) begin
        aleg[i] <= '0;
        bleg[i] <= '0;
      end
    end else begin
      av <= {av[D-2:0], ifa.dp_validIn};
      bv <= {bv[D-2:0], ifb.dp_validIn};
      aleg[0] <= ifa.dp_leg;
      bleg[0] <= ifb.dp_leg;
      for (int i = 1; i < D; i++) begin
        aleg[i] <= aleg[i-1];
        bleg[i] <= bleg[i-1];
      end
    end
  end

  assign ifa.dp_validOut = av[D-1] | inj_a;
  assign ifa.dp_LUTin    = inj_a ? 17'sd777 : 17'(100 * int'(aleg[D-1]));
  assign ifa.dp_atan     = inj_a ? 13'sd55  : 13'(-int'(aleg[D-1]));
  assign ifb.dp_validOut = bv[D-1];
  assign ifb.dp_LUTin    = 17'(100 * int'(bleg[D-1]));
  assign ifb.dp_atan     = 13'(-int'(bleg[D-1]));

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function automatic void flag(string name);
    checks++;
    errors++;
    $display("FAIL %s: output seen with nothing expected", name);
  endfunction

  function automatic bank_t exp_bank(int c);
    bank_t b;
    b.lut  = '0;
    b.atan = '0;
    for (int k = 0; k < NL; k++) begin
      b.lut[17*k +: 17]  = 17'(100 * k);
      b.atan[13*k +: 13] = 13'(-k);
    end
    b.cyc = c;
    return b;
  endfunction

  task automatic set_vectors(input int sx, input int ox, input int sy, input int oy, input int lz);
    for (int k = 0; k < NL; k++) begin
      lx_all[9*k +: 9] = 9'(sx * k + ox);
      ly_all[9*k +: 9] = 9'(sy * k + oy);
      lz_all[9*k +: 9] = 9'(lz);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Called #1 after an edge; start is sampled at the next edge (cycle 0 of the frame).
  task automatic launch_a(input bit timed);
    iss_t e;
    start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    ta0 = cyc;
    for (int k = 0; k < NL; k++) begin
      e.leg = 3'(k);
      e.lx  = lx_all[9*k +: 9];
      e.ly  = ly_all[9*k +: 9];
      e.lz  = lz_all[9*k +: 9];
      e.cyc = timed ? ta0 + 1 + k : -1;
      qa_iss.push_back(e);
    end
    qa_bank.push_back(exp_bank(timed ? ta0 + NL + D + 1 : -1));
  endtask

  task automatic launch_b();
    iss_t e;
    start_b = 1'b1;
    @(posedge clock);
    #1;
    start_b = 1'b0;
    for (int k = 0; k < NL; k++) begin
      e.leg = 3'(k);
      e.lx  = lx_all[9*k +: 9];
      e.ly  = ly_all[9*k +: 9];
      e.lz  = lz_all[9*k +: 9];
      e.cyc = -1;
      qb_iss.push_back(e);
    end
    qb_bank.push_back(exp_bank(-1));
  endtask

  // Monitor for the depth-8 instance: issues and published banks against the scoreboard.
  always @(negedge clock) begin : mon_a
    iss_t  ie;
    bank_t be;
    if (!reset) begin
      if (ifa.dp_validIn) begin
        n_iss_a++;
        if (qa_iss.size() == 0) flag("a_unexpected_issue");
        else begin
          ie = qa_iss.pop_front();
          check("a_issue_vec", {ifa.dp_leg, ifa.dp_lx, ifa.dp_ly, ifa.dp_lz},
                {ie.leg, ie.lx, ie.ly, ie.lz});
          if (ie.cyc >= 0) check("a_issue_cycle", cyc, ie.cyc);
        end
      end
      if (fd_a) begin
        if (qa_bank.size() == 0) flag("a_unexpected_frame_done");
        else begin
          be = qa_bank.pop_front();
          check("a_bank_lutin", lut_a, be.lut);
          check("a_bank_atan", atan_a, be.atan);
          if (be.cyc >= 0) check("a_frame_done_cycle", cyc, be.cyc);
        end
      end
    end
  end

  // Monitor for the depth-2 instance: outstanding-transaction bound plus scoreboard.
  always @(negedge clock) begin : mon_b
    iss_t  ie;
    bank_t be;
    if (!reset) begin
      if (ifb.dp_validIn) begin
        b_issued++;
        if (b_issued - b_results > b_max_out) b_max_out = b_issued - b_results;
        check("b_outstanding_le2", 128'(b_issued - b_results <= 2), 128'(1));
        if (qb_iss.size() == 0) flag("b_unexpected_issue");
        else begin
          ie = qb_iss.pop_front();
          check("b_issue_vec", {ifb.dp_leg, ifb.dp_lx, ifb.dp_ly, ifb.dp_lz},
                {ie.leg, ie.lx, ie.ly, ie.lz});
        end
      end
      if (ifb.dp_validOut) b_results++;
      if (fd_b) begin
        n_fd_b++;
        if (qb_bank.size() == 0) flag("b_unexpected_frame_done");
        else begin
          be = qb_bank.pop_front();
          check("b_bank_lutin", lut_b, be.lut);
          check("b_bank_atan", atan_b, be.atan);
        end
      end
    end
  end

  initial begin : stim
    int s;
    int n0;
    bank_t eb;
    set_vectors(1, 1, -1, -1, 20);
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_validin", ifa.dp_validIn, 0);
    check("rst_leg", ifa.dp_leg, 0);
    check("rst_frame_done", fd_a, 0);
    check("rst_orphan", orph_a, 0);
    check("rst_lutin", lut_a, 0);
    check("rst_atan", atan_a, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Single frame, no back-pressure.
    launch_a(1);
    wait_cyc(ta0 + 14);
    check("t1_lutin_leg3", lut_a[17*3 +: 17], 17'd300);
    check("t1_atan_leg5", atan_a[13*5 +: 13], 13'h1ffb);
    check("t1_drained", qa_iss.size() + qa_bank.size(), 0);

    // Starts during ISSUE and DRAIN are ignored; start in the frame_done cycle is accepted.
    set_vectors(2, -5, 3, 4, -9);
    launch_a(1);
    s  = ta0;
    n0 = n_iss_a;
    wait_cyc(s + 3);
    start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    wait_cyc(s + 9);
    start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    wait_cyc(s + 12);
    check("t3_frame_done_high", fd_a, 1);
    launch_a(1);
    check("t3_issue_count", n_iss_a - n0, 6);
    wait_cyc(ta0 + 14);
    check("t3_drained", qa_iss.size() + qa_bank.size(), 0);

    // Back-pressure on the depth-2 instance.
    set_vectors(5, 7, -4, 2, 33);
    launch_b();
    for (int i = 0; i < 200 && n_fd_b == 0; i++) begin
      @(posedge clock);
      #1;
    end
    repeat (20) @(posedge clock);
    #1;
    check("t2_frame_done_once", n_fd_b, 1);
    check("t2_max_outstanding", b_max_out, 2);
    check("t2_drained", qb_iss.size() + qb_bank.size(), 0);
    check("t2_not_busy", busy_b, 0);

    // Orphan result in IDLE.
    eb = exp_bank(-1);
    inj_a = 1'b1;
    @(posedge clock);
    #1;
    inj_a = 1'b0;
    check("orphan_set", orph_a, 1);
    repeat (10) @(posedge clock);
    #1;
    check("orphan_sticky", orph_a, 1);
    check("orphan_bank_lutin", lut_a, eb.lut);
    check("orphan_bank_atan", atan_a, eb.atan);
    check("orphan_b_clear", orph_b, 0);

    // Inputs change right after start; snapshot is used and the bank holds.
    set_vectors(-3, 40, 7, -60, 100);
    launch_a(1);
    for (int k = 0; k < NL; k++) begin
      lx_all[9*k +: 9] = 9'($urandom);
      ly_all[9*k +: 9] = 9'($urandom);
    end
    wait_cyc(ta0 + 13);
    for (int i = 0; i < 50; i++) begin
      lz_all[8:0] = 9'($urandom);
      check("hold_lutin", lut_a, eb.lut);
      check("hold_atan", atan_a, eb.atan);
      @(posedge clock);
      #1;
    end
    check("hold_drained", qa_iss.size() + qa_bank.size(), 0);

    // Reset in DRAIN after three results: abandoned frame, then a clean frame.
    set_vectors(1, 1, -1, -1, 20);
    launch_a(1);
    wait_cyc(ta0 + 9);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_validin", ifa.dp_validIn, 0);
    check("mid_rst_frame_done", fd_a, 0);
    check("mid_rst_orphan", orph_a, 0);
    check("mid_rst_lutin", lut_a, 0);
    check("mid_rst_atan", atan_a, 0);
    qa_iss.delete();
    qa_bank.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    check("post_rst_idle", busy_a, 0);
    check("post_rst_lutin", lut_a, 0);
    launch_a(1);
    wait_cyc(ta0 + 14);
    check("post_rst_lutin_leg3", lut_a[17*3 +: 17], 17'd300);
    check("post_rst_drained", qa_iss.size() + qa_bank.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
